// File: rtl/cpld_uart_bridge.sv
// rdn/wrn byte-strobe UART device: THR/TSR transmit path, 16x oversampled RBR receive path, 8N1.
// Define UART_LOOPBACK_EN to feed RX from the internal TX stream and park txd high.
module cpld_uart_bridge #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rdn,
    input  logic       uart_wrn,
    input  logic [7:0] bus_data_in,
    output logic [7:0] bus_data_out,
    output logic       bus_data_oe,
    output logic       uart_dataready,
    output logic       uart_tbre,
    output logic       uart_tsre,
    output logic       txd,
    input  logic       rxd
);

    localparam int BIT_DIV  = CLK_FREQ / BAUD;
    localparam int TICK_RAW = CLK_FREQ / (16 * BAUD);
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int BIT_W    = $clog2(BIT_DIV);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BIT_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [1:0] rdn_sync, wrn_sync, rx_sync;
    logic       rdn_prev, wrn_prev, rx_prev;
    logic       rdn_rise, wrn_rise, rx_fall, rx_src, rx_bit;
    logic [7:0] hold, thr, tsr, rbr, rx_shift;
    logic       tx_line;

    tx_state_t        tx_state, tx_state_nxt;
    logic [BIT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic             tx_bit_end, tx_load, tx_done;

    rx_state_t         rx_state, rx_state_nxt;
    logic [TICK_W-1:0] tick_cnt;
    logic [3:0]        rx_cnt;
    logic [2:0]        rx_idx;
    logic              rx_tick, rx_sample, rx_commit;

`ifdef UART_LOOPBACK_EN
    assign rx_src = tx_line;
    assign txd    = 1'b1;
`else
    assign rx_src = rxd;
    assign txd    = tx_line;
`endif

    assign bus_data_oe  = ~uart_rdn & rst_n;
    assign bus_data_out = rbr;
    assign rdn_rise     = rdn_sync[1] & ~rdn_prev;
    assign wrn_rise     = wrn_sync[1] & ~wrn_prev;
    assign rx_fall      = ~rx_sync[1] & rx_prev;
    assign rx_bit       = rx_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdn_sync <= '1;
            wrn_sync <= '1;
            rx_sync  <= '1;
            rdn_prev <= 1'b1;
            wrn_prev <= 1'b1;
            rx_prev  <= 1'b1;
            hold     <= '0;
        end else begin
            rdn_sync <= {rdn_sync[0], uart_rdn};
            wrn_sync <= {wrn_sync[0], uart_wrn};
            rx_sync  <= {rx_sync[0], rx_src};
            rdn_prev <= rdn_sync[1];
            wrn_prev <= wrn_sync[1];
            rx_prev  <= rx_sync[1];
            if (!uart_wrn) hold <= bus_data_in;
        end
    end

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_load      = 1'b0;
        tx_done      = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!uart_tbre) begin
                    tx_load      = 1'b1;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: if (tx_bit_end) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_state_nxt = TX_STOP;
            TX_STOP: begin
                // A pending THR byte restarts straight into START: no idle bit between frames.
                if (tx_bit_end) begin
                    if (!uart_tbre) begin
                        tx_load      = 1'b1;
                        tx_state_nxt = TX_START;
                    end else begin
                        tx_done      = 1'b1;
                        tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        case (tx_state)
            TX_START: tx_line = 1'b0;
            TX_DATA:  tx_line = tsr[0];
            default:  tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tsr       <= '0;
            thr       <= '0;
            uart_tbre <= 1'b1;
            uart_tsre <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_state == TX_IDLE || tx_bit_end) tx_cnt <= '0;
            else                                   tx_cnt <= tx_cnt + 1'b1;
            if (tx_state != TX_DATA) tx_idx <= '0;
            else if (tx_bit_end)     tx_idx <= tx_idx + 1'b1;
            if (tx_load)                                tsr <= thr;
            else if (tx_state == TX_DATA && tx_bit_end) tsr <= {1'b0, tsr[7:1]};
            if (tx_load) begin
                uart_tbre <= 1'b1;
            end else if (wrn_rise && uart_tbre) begin
                thr       <= hold;
                uart_tbre <= 1'b0;
            end
            if (tx_load)      uart_tsre <= 1'b0;
            else if (tx_done) uart_tsre <= 1'b1;
        end
    end

    assign rx_tick = (tick_cnt == TICK_LAST);

    always_comb begin
        rx_state_nxt = rx_state;
        rx_commit    = 1'b0;
        rx_sample    = rx_tick && ((rx_state == RX_START) ? (rx_cnt == 4'd7) : (rx_cnt == 4'd15));
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
            RX_START: if (rx_sample) rx_state_nxt = rx_bit ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_sample && rx_idx == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP: begin
                if (rx_sample) begin
                    rx_commit    = rx_bit;
                    rx_state_nxt = RX_IDLE;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state       <= RX_IDLE;
            tick_cnt       <= '0;
            rx_cnt         <= '0;
            rx_idx         <= '0;
            rx_shift       <= '0;
            rbr            <= '0;
            uart_dataready <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            if (rx_state == RX_IDLE || rx_tick) tick_cnt <= '0;
            else                                tick_cnt <= tick_cnt + 1'b1;
            if (rx_state == RX_IDLE || rx_state_nxt != rx_state) rx_cnt <= '0;
            else if (rx_tick)                                    rx_cnt <= rx_cnt + 1'b1;
            if (rx_state != RX_DATA) rx_idx <= '0;
            else if (rx_sample)      rx_idx <= rx_idx + 1'b1;
            if (rx_state == RX_DATA && rx_sample) rx_shift <= {rx_bit, rx_shift[7:1]};
            // A byte landing on the same cycle as the read-clear keeps dataready set.
            if (rx_commit) begin
                rbr            <= rx_shift;
                uart_dataready <= 1'b1;
            end else if (rdn_rise) begin
                uart_dataready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpld_uart_bridge.sv
// Scoreboard bench for cpld_uart_bridge: expected TX frames and RX bytes are queued by the
// stimulus and popped by independent monitors. Define UART_LOOPBACK_EN to run the loopback test.
module tb_cpld_uart_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rdn, uart_wrn, rxd;
    logic [7:0] bus_data_in;
    logic [7:0] bus_data_out;
    logic       bus_data_oe, uart_dataready, uart_tbre, uart_tsre, txd;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [7:0] last_rbr = 8'h00;

    typedef struct packed {
        logic [7:0] data;
        logic       b2b;
        logic       last;
    } tx_exp_t;

    tx_exp_t    tx_exp[$];
    logic [7:0] rx_exp[$];

    cpld_uart_bridge #(.CLK_FREQ(1843200), .BAUD(115200)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
        .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
        .uart_dataready(uart_dataready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre),
        .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none (t=%0t)", name, $time);
    endtask

    // TX monitor: samples a whole 160-cycle frame once txd falls, then scores it.
    initial begin : tx_mon
        logic [159:0] smp;
        logic [9:0]   obs;
        logic         stable, mid_tsre, have_start, got;
        int           start_cyc, prev_start;
        tx_exp_t      e;
        have_start = 1'b0;
        prev_start = 0;
        @(posedge rst_n);
        forever begin
            if (!have_start) begin
                @(negedge clk);
                while (txd !== 1'b0) @(negedge clk);
            end
            have_start = 1'b0;
            start_cyc  = cyc;
            smp[0]     = txd;
            mid_tsre   = 1'b1;
            for (int c = 1; c < 160; c++) begin
                @(negedge clk);
                smp[c] = txd;
                if (c == 80) mid_tsre = uart_tsre;
            end
            stable = 1'b1;
            for (int k = 0; k < 10; k++) begin
                obs[k] = smp[16*k+8];
                for (int j = 0; j < 16; j++)
                    if (smp[16*k+j] !== smp[16*k+8]) stable = 1'b0;
            end
            got = 1'b0;
            e   = '0;
            if (tx_exp.size() == 0) begin
                fail_now("tx_unexpected_frame");
            end else begin
                got = 1'b1;
                e   = tx_exp.pop_front();
                check("tx_frame", {22'd0, obs}, {22'd0, 1'b1, e.data, 1'b0});
                check("tx_bit_width", {31'd0, stable}, 32'd1);
                check("tx_tsre_busy", {31'd0, mid_tsre}, 32'd0);
                if (e.b2b) check("tx_back_to_back", start_cyc - prev_start, 32'd160);
            end
            prev_start = start_cyc;
            @(negedge clk);
            if (got) check("tx_tsre_after_frame", {31'd0, uart_tsre}, {31'd0, e.last});
            if (txd === 1'b0) have_start = 1'b1;
        end
    end

    // RX monitor: every new dataready assertion presents one byte on the bus side.
    initial begin : rx_mon
        logic prev_dr;
        prev_dr = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_dataready === 1'b1 && !prev_dr) begin
                if (rx_exp.size() == 0) fail_now("rx_unexpected_byte");
                else check("rx_byte", {24'd0, bus_data_out}, {24'd0, rx_exp.pop_front()});
            end
            prev_dr = (uart_dataready === 1'b1);
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        bus_data_in = b;
        uart_wrn    = 1'b0;
        repeat (2) @(negedge clk);
        uart_wrn = 1'b1;
    endtask

    task automatic write_idle_check(input logic [7:0] b);
        logic seen;
        write_byte(b);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (uart_tbre === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check("tbre_low_on_write", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("tbre_high_on_load", {31'd0, uart_tbre}, 32'd1);
        check("tsre_low_on_load", {31'd0, uart_tsre}, 32'd0);
    endtask

    task automatic wait_tx_idle();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (uart_tsre === 1'b1 && uart_tbre === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        check("tx_idle_reached", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rxd = frame[k];
            repeat (15) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_byte(input logic [7:0] exp);
        logic cleared;
        @(negedge clk);
        uart_rdn = 1'b0;
        #1;
        check("read_oe_on", {31'd0, bus_data_oe}, 32'd1);
        check("read_data", {24'd0, bus_data_out}, {24'd0, exp});
        repeat (3) @(negedge clk);
        uart_rdn = 1'b1;
        #1;
        check("read_oe_off", {31'd0, bus_data_oe}, 32'd0);
        cleared = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (uart_dataready === 1'b0) begin
                cleared = 1'b1;
                break;
            end
        end
        check("dataready_cleared", {31'd0, cleared}, 32'd1);
    endtask

    initial begin : stim
        logic [7:0] b;
        logic       ok;
        rst_n       = 1'b0;
        uart_rdn    = 1'b0;
        uart_wrn    = 1'b1;
        rxd         = 1'b1;
        bus_data_in = 8'h00;
        #1;
        check("oe_gated_by_reset", {31'd0, bus_data_oe}, 32'd0);
        uart_rdn = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_tbre", {31'd0, uart_tbre}, 32'd1);
        check("rst_tsre", {31'd0, uart_tsre}, 32'd1);
        check("rst_dataready", {31'd0, uart_dataready}, 32'd0);
        check("rst_oe", {31'd0, bus_data_oe}, 32'd0);
        check("rst_bus_out", {24'd0, bus_data_out}, 32'd0);

`ifdef UART_LOOPBACK_EN
        rx_exp.push_back(8'hC3);
        last_rbr = 8'hC3;
        write_byte(8'hC3);
        ok = 1'b1;
        b  = 8'h00;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) ok = 1'b0;
            if (uart_dataready === 1'b1) begin
                b = 8'h01;
                break;
            end
        end
        check("loopback_txd_held", {31'd0, ok}, 32'd1);
        check("loopback_dataready", {24'd0, b}, 32'd1);
        read_byte(8'hC3);
`else
        tx_exp.push_back('{data: 8'hA5, b2b: 1'b0, last: 1'b1});
        write_idle_check(8'hA5);
        wait_tx_idle();

        tx_exp.push_back('{data: 8'h55, b2b: 1'b0, last: 1'b0});
        write_idle_check(8'h55);
        tx_exp.push_back('{data: 8'h0F, b2b: 1'b1, last: 1'b1});
        write_byte(8'h0F);
        repeat (8) @(negedge clk);
        check("tbre_full", {31'd0, uart_tbre}, 32'd0);
        write_byte(8'hEE);
        wait_tx_idle();

        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom);
            tx_exp.push_back('{data: b, b2b: 1'b0, last: 1'b1});
            repeat ($urandom_range(1, 20)) @(negedge clk);
            write_idle_check(b);
            wait_tx_idle();
        end

        rx_exp.push_back(8'h3C);
        last_rbr = 8'h3C;
        send_rx(8'h3C, 1'b1);
        check("rx_dataready_set", {31'd0, uart_dataready}, 32'd1);
        read_byte(8'h3C);

        send_rx(8'h81, 1'b0);
        repeat (8) @(negedge clk);
        check("framing_no_dataready", {31'd0, uart_dataready}, 32'd0);
        check("framing_rbr_kept", {24'd0, bus_data_out}, {24'd0, last_rbr});

        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_dataready", {31'd0, uart_dataready}, 32'd0);

        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom);
            rx_exp.push_back(b);
            last_rbr = b;
            repeat ($urandom_range(1, 20)) @(negedge clk);
            send_rx(b, 1'b1);
            read_byte(b);
        end
`endif

        repeat (10) @(negedge clk);
        check("tx_queue_drained", tx_exp.size(), 32'd0);
        check("rx_queue_drained", rx_exp.size(), 32'd0);

        write_byte(8'h00);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (uart_tsre === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("midframe_tx_started", {31'd0, ok}, 32'd1);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midframe_rst_txd", {31'd0, txd}, 32'd1);
        check("midframe_rst_tsre", {31'd0, uart_tsre}, 32'd1);
        check("midframe_rst_tbre", {31'd0, uart_tbre}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
